branch_predict_unit: RTL and testbench

BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

---
 rtl/branch_predict_unit.sv | 194 +++++++++++++++++++
 tb/tb_branch_predict_unit.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_unit.sv
// branch_predict_unit -- direct-mapped branch target buffer with a 2-bit
// bimodal counter per entry, plus branch / mispredict statistics counters.
//
// Ports
//   clk, reset              : clock, asynchronous active-low reset
//   fetch_pc                : PC looked up this cycle (combinational result)
//   pred_hit/taken/next_pc  : lookup result for fetch_pc
//   upd_*                   : resolved control transfer from execute, applied
//                             at the next rising edge
//   upd_pred_taken/target   : prediction originally made for upd_pc
//   flush                   : invalidate every entry (wins over an update)
//   clr_stats               : zero the statistics (wins over an increment)
//   mispredict              : combinational mispredict flag for the update
//   br_count, mp_count      : saturating statistics counters

// One table entry. The top decodes the update index into upd_en, so each
// entry only decides hit/allocate against its own tag.
module bpu_entry #(
  parameter int XLEN = 32,
  parameter int TW   = 26
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            upd_en,
  input  logic            upd_taken,
  input  logic            upd_is_jump,
  input  logic [TW-1:0]   upd_tag,
  input  logic [XLEN-1:0] upd_target,
  output logic            vld,
  output logic [TW-1:0]   tag,
  output logic [XLEN-1:0] tgt,
  output logic            jmp,
  output logic [1:0]      ctr
);
  logic            vld_q, vld_d;
  logic [TW-1:0]   tag_q, tag_d;
  logic [XLEN-1:0] tgt_q, tgt_d;
  logic            jmp_q, jmp_d;
  logic [1:0]      ctr_q, ctr_d;
  logic            hit;

  always_comb begin
    vld_d = vld_q;
    tag_d = tag_q;
    tgt_d = tgt_q;
    jmp_d = jmp_q;
    ctr_d = ctr_q;
    hit   = vld_q && (tag_q == upd_tag);
    if (flush) begin
      vld_d = 1'b0;
    end else if (upd_en) begin
      if (hit) begin
        if (upd_taken) begin
          ctr_d = (ctr_q == 2'd3) ? 2'd3 : ctr_q + 2'd1;
          tgt_d = upd_target;
          jmp_d = upd_is_jump;
        end else begin
          ctr_d = (ctr_q == 2'd0) ? 2'd0 : ctr_q - 2'd1;
        end
      end else if (upd_taken) begin
        // Taken miss replaces whatever lives at this index.
        vld_d = 1'b1;
        tag_d = upd_tag;
        tgt_d = upd_target;
        jmp_d = upd_is_jump;
        ctr_d = 2'd2;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q <= 1'b0;
      tag_q <= '0;
      tgt_q <= '0;
      jmp_q <= 1'b0;
      ctr_q <= 2'd1;
    end else begin
      vld_q <= vld_d;
      tag_q <= tag_d;
      tgt_q <= tgt_d;
      jmp_q <= jmp_d;
      ctr_q <= ctr_d;
    end
  end

  assign vld = vld_q;
  assign tag = tag_q;
  assign tgt = tgt_q;
  assign jmp = jmp_q;
  assign ctr = ctr_q;
endmodule

module branch_predict_unit #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [XLEN-1:0]  fetch_pc,
  output logic             pred_hit,
  output logic             pred_taken,
  output logic [XLEN-1:0]  pred_next_pc,
  input  logic             upd_valid,
  input  logic [XLEN-1:0]  upd_pc,
  input  logic             upd_is_jump,
  input  logic             upd_taken,
  input  logic [XLEN-1:0]  upd_target,
  input  logic             upd_pred_taken,
  input  logic [XLEN-1:0]  upd_pred_target,
  input  logic             flush,
  input  logic             clr_stats,
  output logic             mispredict,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mp_count
);
  localparam int IW = $clog2(ENTRIES);
  localparam int TW = XLEN - IW - 2;

  logic [ENTRIES-1:0]           ent_vld;
  logic [ENTRIES-1:0][TW-1:0]   ent_tag;
  logic [ENTRIES-1:0][XLEN-1:0] ent_tgt;
  logic [ENTRIES-1:0]           ent_jmp;
  logic [ENTRIES-1:0][1:0]      ent_ctr;

  logic [IW-1:0] f_idx, u_idx;
  logic [TW-1:0] f_tag, u_tag;
  logic          unused_pc_lsbs;

  assign f_idx = fetch_pc[IW+1:2];
  assign f_tag = fetch_pc[XLEN-1:IW+2];
  assign u_idx = upd_pc[IW+1:2];
  assign u_tag = upd_pc[XLEN-1:IW+2];
  // Instruction-aligned bits of the update PC carry no table information.
  assign unused_pc_lsbs = ^upd_pc[1:0];

  for (genvar i = 0; i < ENTRIES; i++) begin : g_ent
    bpu_entry #(.XLEN(XLEN), .TW(TW)) u_ent (
      .clk         (clk),
      .reset       (reset),
      .flush       (flush),
      .upd_en      (upd_valid && (u_idx == IW'(i))),
      .upd_taken   (upd_taken),
      .upd_is_jump (upd_is_jump),
      .upd_tag     (u_tag),
      .upd_target  (upd_target),
      .vld         (ent_vld[i]),
      .tag         (ent_tag[i]),
      .tgt         (ent_tgt[i]),
      .jmp         (ent_jmp[i]),
      .ctr         (ent_ctr[i])
    );
  end

  // Lookup reads registered contents only: a same-cycle update is not
  // forwarded.
  assign pred_hit     = ent_vld[f_idx] && (ent_tag[f_idx] == f_tag);
  assign pred_taken   = pred_hit && (ent_jmp[f_idx] || ent_ctr[f_idx][1]);
  assign pred_next_pc = pred_taken ? ent_tgt[f_idx] : fetch_pc + XLEN'(4);

  assign mispredict = upd_valid &&
                      ((upd_taken != upd_pred_taken) ||
                       (upd_taken && (upd_target != upd_pred_target)));

  logic [CNT_W-1:0] br_count_q, br_count_d;
  logic [CNT_W-1:0] mp_count_q, mp_count_d;

  always_comb begin
    br_count_d = br_count_q;
    mp_count_d = mp_count_q;
    if (clr_stats) begin
      br_count_d = '0;
      mp_count_d = '0;
    end else begin
      if (upd_valid  && !(&br_count_q)) br_count_d = br_count_q + CNT_W'(1);
      if (mispredict && !(&mp_count_q)) mp_count_d = mp_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      br_count_q <= '0;
      mp_count_q <= '0;
    end else begin
      br_count_q <= br_count_d;
      mp_count_q <= mp_count_d;
    end
  end

  assign br_count = br_count_q;
  assign mp_count = mp_count_q;
endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed + randomized bench for branch_predict_unit. A second, narrow
// instance (ENTRIES=2, CNT_W=4) shares the stimulus so counter saturation
// is reached within a short run.
module tb_branch_predict_unit;
  logic        clk, reset;
  logic [31:0] fetch_pc, upd_pc, upd_target, upd_pred_target;
  logic        upd_valid, upd_is_jump, upd_taken, upd_pred_taken, flush, clr_stats;

  logic        pred_hit, pred_taken, mispredict;
  logic [31:0] pred_next_pc;
  logic [15:0] br_count, mp_count;

  logic        s_hit, s_taken, s_misp;
  logic [31:0] s_next;
  logic [3:0]  s_br, s_mp;

  branch_predict_unit #(.XLEN(32), .ENTRIES(16), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .fetch_pc(fetch_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_next_pc(pred_next_pc),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_jump(upd_is_jump),
    .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .flush(flush), .clr_stats(clr_stats), .mispredict(mispredict),
    .br_count(br_count), .mp_count(mp_count));

  branch_predict_unit #(.XLEN(32), .ENTRIES(2), .CNT_W(4)) u_small (
    .clk(clk), .reset(reset), .fetch_pc(fetch_pc),
    .pred_hit(s_hit), .pred_taken(s_taken), .pred_next_pc(s_next),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_jump(upd_is_jump),
    .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
    .flush(flush), .clr_stats(clr_stats), .mispredict(s_misp),
    .br_count(s_br), .mp_count(s_mp));

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model: table of 16 entries addressed by pc/4 mod 16.
  bit          m_vld[16];
  logic [31:0] m_tag[16];
  logic [31:0] m_tgt[16];
  bit          m_jmp[16];
  int          m_ctr[16];
  int          m_br, m_mp, ms_br, ms_mp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_misp();
    return upd_valid && ((upd_taken != upd_pred_taken) ||
                         (upd_taken && (upd_target != upd_pred_target)));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_vld[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_jmp[i] = 0; m_ctr[i] = 1;
    end
    m_br = 0; m_mp = 0; ms_br = 0; ms_mp = 0;
  endtask

  task automatic model_lookup(input logic [31:0] pc, output bit h, output bit t,
                              output logic [31:0] n);
    int i;
    i = (pc / 4) % 16;
    h = m_vld[i] && (m_tag[i] == pc / 64);
    t = h && (m_jmp[i] || m_ctr[i] >= 2);
    n = t ? m_tgt[i] : pc + 32'd4;
  endtask

  task automatic model_edge();
    int  i;
    bit  mp;
    mp = model_misp();
    if (clr_stats) begin
      m_br = 0; m_mp = 0; ms_br = 0; ms_mp = 0;
    end else begin
      if (upd_valid) begin
        m_br  = (m_br  < 65535) ? m_br  + 1 : 65535;
        ms_br = (ms_br < 15)    ? ms_br + 1 : 15;
      end
      if (mp) begin
        m_mp  = (m_mp  < 65535) ? m_mp  + 1 : 65535;
        ms_mp = (ms_mp < 15)    ? ms_mp + 1 : 15;
      end
    end
    if (flush) begin
      for (int k = 0; k < 16; k++) m_vld[k] = 0;
    end else if (upd_valid) begin
      i = (upd_pc / 4) % 16;
      if (m_vld[i] && m_tag[i] == upd_pc / 64) begin
        if (upd_taken) begin
          m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
          m_tgt[i] = upd_target;
          m_jmp[i] = upd_is_jump;
        end else begin
          m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
        end
      end else if (upd_taken) begin
        m_vld[i] = 1; m_tag[i] = upd_pc / 64; m_tgt[i] = upd_target;
        m_jmp[i] = upd_is_jump; m_ctr[i] = 2;
      end
    end
  endtask

  task automatic set_idle();
    upd_valid = 0; upd_pc = 0; upd_is_jump = 0; upd_taken = 0; upd_target = 0;
    upd_pred_taken = 0; upd_pred_target = 0; flush = 0; clr_stats = 0;
  endtask

  task automatic upd(input logic [31:0] pc, input bit jump, input bit taken,
                     input logic [31:0] tgt, input bit ptaken, input logic [31:0] ptgt);
    upd_valid = 1; upd_pc = pc; upd_is_jump = jump; upd_taken = taken;
    upd_target = tgt; upd_pred_taken = ptaken; upd_pred_target = ptgt;
  endtask

  // Check every output against the model, then advance one clock.
  task automatic cycle();
    bit h, t;
    logic [31:0] n;
    #1;
    model_lookup(fetch_pc, h, t, n);
    chk("m_hit",   pred_hit, h);
    chk("m_taken", pred_taken, t);
    chk("m_next",  pred_next_pc, n);
    chk("m_misp",  mispredict, model_misp());
    chk("m_br",    br_count, m_br);
    chk("m_mp",    mp_count, m_mp);
    chk("s_br",    s_br, ms_br);
    chk("s_mp",    s_mp, ms_mp);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic expect_fetch(input string tag, input logic [31:0] pc, input bit h,
                              input bit t, input logic [31:0] n);
    fetch_pc = pc;
    #1;
    chk({tag, "_hit"},   pred_hit, h);
    chk({tag, "_taken"}, pred_taken, t);
    chk({tag, "_next"},  pred_next_pc, n);
  endtask

  initial begin
    reset = 0;
    set_idle();
    fetch_pc = 32'h100;
    model_reset();
    #5;
    expect_fetch("in_reset", 32'h100, 0, 0, 32'h104);
    @(negedge clk);
    reset = 1;
    @(negedge clk);

    // Out of reset: empty table, zero counters.
    expect_fetch("rst", 32'h100, 0, 0, 32'h104);
    chk("rst_br", br_count, 0);
    chk("rst_mp", mp_count, 0);
    cycle();

    // Taken allocate, predicted not-taken.
    upd(32'h100, 0, 1, 32'h80, 0, 0);
    #1 chk("alloc_misp", mispredict, 1);
    cycle();
    set_idle();
    expect_fetch("alloc", 32'h100, 1, 1, 32'h80);
    chk("alloc_br", br_count, 1);
    chk("alloc_mp", mp_count, 1);
    cycle();

    // Counter walks 2 -> 1 -> 0 -> 0, then back up to 2.
    for (int k = 0; k < 3; k++) begin
      upd(32'h100, 0, 0, 0, 1, 32'h80);
      cycle();
    end
    set_idle();
    expect_fetch("ctr0", 32'h100, 1, 0, 32'h104);
    upd(32'h100, 0, 1, 32'h80, 0, 0);
    cycle();
    set_idle();
    expect_fetch("ctr1", 32'h100, 1, 0, 32'h104);
    upd(32'h100, 0, 1, 32'h80, 0, 0);
    cycle();
    set_idle();
    expect_fetch("ctr2", 32'h100, 1, 1, 32'h80);

    // Same index, different tag replaces the entry.
    upd(32'h140, 0, 1, 32'h40, 0, 0);
    cycle();
    set_idle();
    expect_fetch("repl_new", 32'h140, 1, 1, 32'h40);
    expect_fetch("repl_old", 32'h100, 0, 0, 32'h104);

    // Jump bit survives a not-taken branch update.
    upd(32'h200, 1, 1, 32'h300, 0, 0);
    cycle();
    upd(32'h200, 0, 0, 0, 0, 0);
    #1 chk("nt_misp", mispredict, 0);
    cycle();
    set_idle();
    expect_fetch("jmp_keep", 32'h200, 1, 1, 32'h300);

    // Flush beats a simultaneous taken update, which is still counted.
    upd(32'h180, 0, 1, 32'h500, 0, 0);
    flush = 1;
    cycle();
    set_idle();
    expect_fetch("flush_a", 32'h200, 0, 0, 32'h204);
    expect_fetch("flush_b", 32'h180, 0, 0, 32'h184);
    chk("flush_br", br_count, 10);
    cycle();

    // Randomized traffic over a few tags so indices collide.
    for (int k = 0; k < 400; k++) begin
      logic [31:0] tg, tgt;
      case ($urandom_range(0, 3))
        0: tg = 32'h0;
        1: tg = 32'h1;
        2: tg = 32'h2;
        default: tg = 32'h3FF_FFFF;
      endcase
      set_idle();
      tgt = $urandom;
      if ($urandom_range(0, 3) != 0)
        upd((tg << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), tgt,
            1'($urandom_range(0, 1)), ($urandom_range(0, 1) != 0) ? tgt : $urandom);
      flush     = ($urandom_range(0, 39) == 0);
      clr_stats = ($urandom_range(0, 49) == 0);
      case ($urandom_range(0, 3))
        0: tg = 32'h0;
        1: tg = 32'h1;
        2: tg = 32'h2;
        default: tg = 32'h3FF_FFFF;
      endcase
      fetch_pc = (tg << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      cycle();
    end

    // clr_stats beats a simultaneous increment.
    set_idle();
    upd(32'h100, 0, 1, 32'h80, 0, 0);
    clr_stats = 1;
    cycle();
    set_idle();
    #1;
    chk("clr_br", br_count, 0);
    chk("clr_mp", mp_count, 0);

    // 20 updates: the 4-bit instance must pin at all-ones.
    for (int k = 0; k < 20; k++) begin
      upd(32'h40 + 32'(k * 4), 0, 1, $urandom, 0, 0);
      cycle();
    end
    set_idle();
    #1;
    chk("sat_small_br", s_br, 4'hF);
    chk("sat_small_mp", s_mp, 4'hF);
    chk("sat_main_br", br_count, 20);

    // Reset arriving mid-update leaves nothing written.
    upd(32'h180, 0, 1, 32'h600, 0, 0);
    cycle();
    upd(32'h1C0, 0, 1, 32'h700, 0, 0);
    fetch_pc = 32'h180;
    #3 reset = 0;
    #1;
    chk("midrst_hit", pred_hit, 0);
    chk("midrst_next", pred_next_pc, 32'h184);
    chk("midrst_br", br_count, 0);
    chk("midrst_mp", mp_count, 0);
    @(posedge clk);
    @(negedge clk);
    set_idle();
    reset = 1;
    model_reset();
    expect_fetch("postrst_a", 32'h1C0, 0, 0, 32'h1C4);
    expect_fetch("postrst_b", 32'h180, 0, 0, 32'h184);
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
